// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit owning the HI/LO pair.
// Define MDU_MACC_EN to enable madd/maddu/msub/msubu (ops 9-12).
module mdu_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [3:0]       XALUOp,
  input  logic             Start,
  input  logic             Flush,
  output logic [WIDTH-1:0] XALU_Out,
  output logic             Busy,
  output logic             Done
);

  localparam int W2   = 2 * WIDTH;
  localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sgn;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             q_neg;
  logic             r_neg;
`ifdef MDU_MACC_EN
  logic             acc_en;
  logic             acc_sub;
  logic [W2-1:0]    snap;
`endif

  logic go;
  logic is_mthi;
  logic is_mtlo;
  logic is_mul;
  logic is_div;
  logic is_sgn;

  always_comb begin
    go      = Start & ~Busy & ~Flush;
    is_mthi = (XALUOp == 4'd3);
    is_mtlo = (XALUOp == 4'd4);
    is_div  = (XALUOp == 4'd7) | (XALUOp == 4'd8);
`ifdef MDU_MACC_EN
    is_mul  = (XALUOp == 4'd1) | (XALUOp == 4'd2) |
              ((XALUOp >= 4'd9) & (XALUOp <= 4'd12));
`else
    is_mul  = (XALUOp == 4'd1) | (XALUOp == 4'd2);
`endif
    is_sgn  = (XALUOp == 4'd1) | (XALUOp == 4'd7) |
              (XALUOp == 4'd9) | (XALUOp == 4'd11);
  end

  always_comb begin
    XALU_Out = '0;
    unique case (1'b1)
      (XALUOp == 4'd5): XALU_Out = hi;
      (XALUOp == 4'd6): XALU_Out = lo;
      default:          XALU_Out = '0;
    endcase
  end

  // Product settles across the MUL_LAT busy cycles from latched operands.
  logic [W2-1:0] ax;
  logic [W2-1:0] bx;
  logic [W2-1:0] prod;
  logic [W2-1:0] res;

  always_comb begin
    ax   = {{WIDTH{sgn & op_a[WIDTH-1]}}, op_a};
    bx   = {{WIDTH{sgn & op_b[WIDTH-1]}}, op_b};
    prod = ax * bx;
`ifdef MDU_MACC_EN
    res  = acc_en ? (acc_sub ? snap - prod : snap + prod) : prod;
`else
    res  = prod;
`endif
  end

  logic [WIDTH:0]   shf;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  always_comb begin
    a_abs  = (sgn & op_a[WIDTH-1]) ? -op_a : op_a;
    b_abs  = (sgn & op_b[WIDTH-1]) ? -op_b : op_b;
    shf    = {rem, quo[WIDTH-1]};
    ge     = (shf >= {1'b0, dvs});
    rem_nx = ge ? WIDTH'(shf - {1'b0, dvs}) : shf[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      sgn   <= 1'b0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
`ifdef MDU_MACC_EN
      acc_en  <= 1'b0;
      acc_sub <= 1'b0;
      snap    <= '0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            unique case (1'b1)
              is_mthi: hi <= D1;
              is_mtlo: lo <= D1;
              is_mul: begin
                op_a  <= D1;
                op_b  <= D2;
                sgn   <= is_sgn;
                cnt   <= CW'(MUL_LAT - 1);
                state <= MUL;
                Busy  <= 1'b1;
`ifdef MDU_MACC_EN
                acc_en  <= (XALUOp >= 4'd9);
                acc_sub <= (XALUOp >= 4'd11);
                snap    <= {hi, lo};
`endif
              end
              is_div: begin
                // Divide by zero finishes at once with HI/LO untouched.
                if (D2 == '0) begin
                  Done <= 1'b1;
                end else begin
                  op_a  <= D1;
                  op_b  <= D2;
                  sgn   <= is_sgn;
                  cnt   <= CW'(WIDTH);
                  state <= DIV;
                  Busy  <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          if (Flush) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
          end else if (cnt == '0) begin
            {hi, lo} <= res;
            state    <= IDLE;
            Busy     <= 1'b0;
            Done     <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV: begin
          if (Flush) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
          end else if (cnt == CW'(WIDTH)) begin
            quo   <= a_abs;
            dvs   <= b_abs;
            rem   <= '0;
            q_neg <= sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            r_neg <= sgn & op_a[WIDTH-1];
            cnt   <= cnt - 1'b1;
          end else begin
            quo <= quo_nx;
            rem <= rem_nx;
            if (cnt == '0) begin
              hi    <= r_neg ? -rem_nx : rem_nx;
              lo    <= q_neg ? -quo_nx : quo_nx;
              state <= IDLE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: random + directed checks of mdu_iter against an
// arithmetic HI/LO model; also a WIDTH=16, MUL_LAT=1 instance.
module tb_mdu_iter;

  localparam int W   = 32;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  D1;
  logic [W-1:0]  D2;
  logic [3:0]    XALUOp;
  logic          Start;
  logic          Flush;
  logic [W-1:0]  XALU_Out;
  logic          Busy;
  logic          Done;

  logic [15:0]   h_d1;
  logic [15:0]   h_d2;
  logic [3:0]    h_op;
  logic          h_start;
  logic [15:0]   h_out;
  logic          h_busy;
  logic          h_done;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .D1(D1), .D2(D2),
    .XALUOp(XALUOp), .Start(Start), .Flush(Flush),
    .XALU_Out(XALU_Out), .Busy(Busy), .Done(Done)
  );

  mdu_iter #(.WIDTH(16), .MUL_LAT(1)) u16 (
    .clk(clk), .reset(reset), .D1(h_d1), .D2(h_d2),
    .XALUOp(h_op), .Start(h_start), .Flush(1'b0),
    .XALU_Out(h_out), .Busy(h_busy), .Done(h_done)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: HI/LO effect and timing class of one accepted op.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int eb,
                       output bit ed);
    logic [63:0] p;
    logic [63:0] acc;
    logic [63:0] ua;
    logic [63:0] ub;
    longint q;
    longint r;
    bit mac_on;
`ifdef MDU_MACC_EN
    mac_on = 1'b1;
`else
    mac_on = 1'b0;
`endif
    eb = 0;
    ed = 1'b0;
    if (op inside {1, 2} || (mac_on && op inside {[9:12]})) begin
      ua = {32'b0, a};
      ub = {32'b0, b};
      if (op inside {1, 9, 11})
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
      else
        p = ua * ub;
      acc = {m_hi, m_lo};
      if (op inside {9, 10}) acc = acc + p;
      else if (op inside {11, 12}) acc = acc - p;
      else acc = p;
      {m_hi, m_lo} = acc;
      eb = LAT;
      ed = 1'b1;
    end else if (op == 4'd3) begin
      m_hi = a;
    end else if (op == 4'd4) begin
      m_lo = a;
    end else if (op inside {7, 8}) begin
      ed = 1'b1;
      if (b != 0) begin
        eb = W + 1;
        if (op == 4'd7) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
        end else begin
          q = longint'({32'b0, a}) / longint'({32'b0, b});
          r = longint'({32'b0, a}) % longint'({32'b0, b});
        end
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
    end
  endtask

  task automatic read_hl(output logic [W-1:0] h, output logic [W-1:0] l);
    XALUOp = 4'd5;
    #1 h = XALU_Out;
    XALUOp = 4'd6;
    #1 l = XALU_Out;
  endtask

  task automatic check_hl(input string tag);
    logic [W-1:0] h;
    logic [W-1:0] l;
    read_hl(h, l);
    check({tag, "_hi"}, h, m_hi);
    check({tag, "_lo"}, l, m_lo);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int nb;
    int nd;
    int di;
    int eb;
    bit ed;
    logic [W-1:0] ohi;
    nb = 0;
    nd = 0;
    di = -1;
    ohi = m_hi;
    @(negedge clk);
    XALUOp = op;
    D1 = a;
    D2 = b;
    Start = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      Start = 1'b0;
      XALUOp = 4'd5;
      #1;
      if (i == 0 && Busy) check("mfhi_busy", XALU_Out, ohi);
      if (Busy) nb++;
      if (Done) begin
        nd++;
        if (di < 0) di = i;
      end
    end
    model(op, a, b, eb, ed);
    check($sformatf("busy_op%0d", op), nb, eb);
    check($sformatf("done_op%0d", op), nd, ed ? 1 : 0);
    if (ed) check($sformatf("done_at_op%0d", op), di, eb);
    check_hl($sformatf("res_op%0d", op));
  endtask

  task automatic run16(input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input int eb,
                       input logic [15:0] ehi, input logic [15:0] elo);
    int nb;
    nb = 0;
    @(negedge clk);
    h_op = op;
    h_d1 = a;
    h_d2 = b;
    h_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      h_start = 1'b0;
      h_op = 4'd0;
      if (h_busy) nb++;
    end
    check("w16_busy", nb, eb);
    h_op = 4'd5;
    #1 check("w16_hi", h_out, ehi);
    h_op = 4'd6;
    #1 check("w16_lo", h_out, elo);
  endtask

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [W-1:0] h;
    logic [W-1:0] l;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int nd;
    int n;
    int eb;
    bit ed;
    reset = 1'b1;
    Start = 1'b0;
    Flush = 1'b0;
    XALUOp = 4'd0;
    D1 = '0;
    D2 = '0;
    h_start = 1'b0;
    h_op = 4'd0;
    h_d1 = '0;
    h_d2 = '0;
    m_hi = '0;
    m_lo = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check_hl("rst");

    // Start on the first edge after reset release.
    @(negedge clk);
    reset = 1'b0;
    XALUOp = 4'd3;
    D1 = 32'h0000_0abc;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    m_hi = 32'h0000_0abc;
    check_hl("post_rst");
    XALUOp = 4'd0;
    #1 check("out_nop", XALU_Out, 0);

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_hi_abs", m_hi, 32'hFFFF_FFFF);
    run_op(4'd7, 32'hFFFF_FFF9, 32'd2);
    run_op(4'd8, 32'hFFFF_FFF9, 32'd2);
    run_op(4'd3, 32'd5, 32'd0);
    run_op(4'd4, 32'd7, 32'd0);
    run_op(4'd8, 32'h1234_5678, 32'd0);
    run_op(4'd7, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(4'd3, 32'd0, 32'd0);
    run_op(4'd4, 32'd10, 32'd0);
    run_op(4'd9, 32'd3, 32'd4);
    run_op(4'd12, 32'd5, 32'd5);

    // Flush mid-divide, then Flush together with Start while idle.
    run_op(4'd3, 32'h1111, 32'd0);
    run_op(4'd4, 32'h2222, 32'd0);
    @(negedge clk);
    XALUOp = 4'd7;
    D1 = W'($urandom);
    D2 = 32'd7;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    check("flush_busy", Busy, 0);
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      if (Done) nd++;
      @(negedge clk);
    end
    check("flush_done", nd, 0);
    XALUOp = 4'd3;
    D1 = 32'h9999;
    Start = 1'b1;
    Flush = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    Flush = 1'b0;
    check_hl("flush");

    // Second Start while busy is dropped.
    ra = W'($urandom);
    rb = W'($urandom);
    @(negedge clk);
    XALUOp = 4'd2;
    D1 = ra;
    D2 = rb;
    Start = 1'b1;
    @(negedge clk);
    XALUOp = 4'd3;
    D1 = 32'hDEAD;
    @(negedge clk);
    Start = 1'b0;
    XALUOp = 4'd0;
    n = 0;
    while (Busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ign_busy", Busy, 0);
    model(4'd2, ra, rb, eb, ed);
    check_hl("ign");

    // Asynchronous reset during a multiply.
    @(negedge clk);
    XALUOp = 4'd1;
    D1 = 32'h0001_2345;
    D2 = 32'h0000_0777;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check("arst_busy", Busy, 0);
    m_hi = '0;
    m_lo = '0;
    read_hl(h, l);
    check("arst_hi", h, 0);
    check("arst_lo", l, 0);
    @(negedge clk);
    reset = 1'b0;
    check("arst_done", Done, 0);

    run16(4'd2, 16'hFFFF, 16'hFFFF, 1, 16'hFFFE, 16'h0001);
    run16(4'd8, 16'd1000, 16'd7, 17, 16'(1000 % 7), 16'(1000 / 7));

    for (int k = 0; k < 60; k++)
      run_op(4'($urandom_range(0, 14)), rnd(), rnd());

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width in bits (even, >= 8).
REQ-002 Parameter MUL_LAT, default 5, multiply-class busy cycles (>= 1).
REQ-003 Port clk  input  1  system clock, all state on rising edge.
REQ-004 Port reset  input  1  asynchronous active-high reset.
REQ-005 Port D1  input  WIDTH  operand A (rs).
REQ-006 Port D2  input  WIDTH  operand B (rt).
REQ-007 Port XALUOp  input  4  operation: 1 mult, 2 multu, 3 mthi, 4 mtlo, 5 mfhi, 6 mflo, 7 div, 8 divu, 9 madd, 10 maddu, 11 msub, 12 msubu; others no-op.
REQ-008 Port Start  input  1  request to launch XALUOp (ops 1-4, 7-12).
REQ-009 Port Flush  input  1  abandon in-flight operation (exception/eret).
REQ-010 Port XALU_Out  output  WIDTH  HI when XALUOp==5, LO when XALUOp==6, else 0.
REQ-011 Port Busy  output  1  operation in flight.
REQ-012 Port Done  output  1  one-cycle pulse when HI/LO commit from a timed op.

Function
REQ-013 Start accepted only when Busy==0 and Flush==0; Start while Busy ignored, no queuing.
REQ-014 mthi/mtlo: HI or LO <= D1 on accepting edge; Busy stays 0; no Done.
REQ-015 mult/multu/madd/maddu/msub/msubu: operands and HI/LO snapshot latched on accept; Busy high for exactly MUL_LAT cycles starting next cycle.
REQ-016 Multiply-class {HI,LO} commits on the edge ending the last Busy cycle; Done high the following cycle (coincides with Busy==0); HI/LO hold old values while Busy.
REQ-017 Products are 2*WIDTH bits, signed for mult/madd/msub, unsigned otherwise; accumulate ops add/subtract product to snapshot {HI,LO} modulo 2^(2*WIDTH).
REQ-018 div/divu: iterative radix-2 restoring divider, one quotient bit per cycle; Busy high exactly WIDTH+1 cycles (1 setup + WIDTH iterations); commit/Done as REQ-016.
REQ-019 divu: LO=floor(D1/D2), HI=D1 mod D2.
REQ-020 div: quotient truncated toward zero, remainder carries dividend sign; D1=min negative, D2=-1 yields LO=min negative, HI=0.
REQ-021 D2==0 for div/divu: accepted, Busy stays 0, HI/LO unchanged, Done pulses next cycle.
REQ-022 Flush while Busy: operation abandoned, HI/LO unchanged, Busy 0 next cycle, no Done; Flush with Start same cycle: Start ignored.
REQ-023 XALU_Out combinational, valid regardless of Busy (returns committed HI/LO); stall of mfhi/mflo while Busy is the pipeline's responsibility.
REQ-024 State machine IDLE -> MUL (counter MUL_LAT-1..0) or DIV (counter WIDTH..0) -> IDLE; Done registered from commit.

Reset
REQ-025 reset asserted: HI=0, LO=0, Busy=0, Done=0, state IDLE, counters 0, immediately (asynchronous), regardless of op in flight.
REQ-026 Start sampled on first rising edge after reset deasserts is honoured normally.

Configuration
REQ-027 Macro MDU_MACC_EN defined: ops 9-12 implemented per REQ-015..017.
REQ-028 Macro MDU_MACC_EN undefined: ops 9-12 are no-ops (no Busy, no Done, HI/LO unchanged); accumulator adder omitted.

Verification
REQ-029 WIDTH=32, MUL_LAT=5: mult D1=0xFFFFFFFE, D2=3, Start -> Busy 5 cycles, Done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFFA; during Busy mfhi returns prior HI.
REQ-030 div D1=0xFFFFFFF9 (-7), D2=2 -> Busy 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; then divu same operands -> LO=0x7FFFFFFC, HI=1.
REQ-031 mthi 5, mtlo 7, divu D2=0 -> Busy never high, Done one cycle, HI=5, LO=7; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-032 HI=0, LO=10, madd D1=3,D2=4 -> LO=22; msubu D1=5,D2=5 -> {HI,LO}=0xFFFFFFFF_FFFFFFFD; with MDU_MACC_EN undefined both leave HI=0, LO=10.
REQ-033 div started, Flush at cycle 10 -> Busy low next cycle, no Done, HI/LO unchanged; second Start during Busy of mult ignored; reset mid-mult -> HI=LO=0, Busy=0 before next edge.
REQ-034 WIDTH=16, MUL_LAT=1: multu 0xFFFF*0xFFFF -> Busy 1 cycle, HI=0xFFFE, LO=0x0001; divu 1000/7 -> Busy 17 cycles, LO=142, HI=6.
